instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_next_pc.sv | 31 +++
 rtl/instr_fetch.sv | 124 ++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
`timescale 1ns/1ps
// Shared types and default widths for the instruction-fetch unit.
package fetch_pkg;

    localparam int PC_W_DEF    = 10;
    localparam int INSTR_W_DEF = 9;
    localparam int OFS_W_DEF   = 8;
    localparam int OPC_W       = 6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HALT
    } state_e;

    typedef enum logic [1:0] {
        NPC_SEQ,
        NPC_REL,
        NPC_ABS
    } npc_sel_e;

endpackage

// File: rtl/fetch_next_pc.sv
`timescale 1ns/1ps
// Next fetch address: sequential, PC-relative (signed offset) or absolute.
// Pure combinational; all arithmetic wraps modulo 2^PC_W.
module fetch_next_pc
    import fetch_pkg::*;
#(
    parameter int PC_W  = PC_W_DEF,
    parameter int OFS_W = OFS_W_DEF
) (
    input  npc_sel_e          sel_i,
    input  logic [PC_W-1:0]   fetch_pc_i,
    input  logic [PC_W-1:0]   instr_pc_i,
    input  logic [OFS_W-1:0]  offset_i,
    input  logic [PC_W-1:0]   target_i,
    output logic [PC_W-1:0]   next_pc_o
);

    logic [PC_W-1:0] ofs_ext;

    assign ofs_ext = PC_W'($signed(offset_i));

    always_comb begin
        next_pc_o = fetch_pc_i + PC_W'(1);
        case (sel_i)
            NPC_REL: next_pc_o = instr_pc_i + ofs_ext;
            NPC_ABS: next_pc_o = target_i;
            default: next_pc_o = fetch_pc_i + PC_W'(1);
        endcase
    end

endmodule

// File: rtl/instr_fetch.sv
`timescale 1ns/1ps
// Instruction fetch: async-read imem, one-deep IR, branch bubble, halt/restart handshake.
// Stall freezes everything; a cleared IR refills before it can be consumed again.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int PC_W    = PC_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int OFS_W   = OFS_W_DEF
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Start,
    input  logic [PC_W-1:0]     StartAddr,
    input  logic                Stall,
    input  logic                BranchTaken,
    input  logic                BranchRel,
    input  logic [OFS_W-1:0]    Offset,
    input  logic [PC_W-1:0]     Target,
    input  logic                HaltReq,
    output logic [PC_W-1:0]     ImemAddr,
    input  logic [INSTR_W-1:0]  ImemData,
    output logic [INSTR_W-1:0]  Instr,
    output logic [OPC_W-1:0]    Opcode,
    output logic                InstrValid,
    output logic [PC_W-1:0]     InstrPC,
    output logic [15:0]         InstrCount,
    output logic                Ack
);

    state_e               state_q, state_d;
    logic [PC_W-1:0]      fetch_pc_q, fetch_pc_d;
    logic [INSTR_W-1:0]   ir_q, ir_d;
    logic [PC_W-1:0]      instr_pc_q, instr_pc_d;
    logic                 valid_q, valid_d;
    logic [15:0]          count_q, count_d;
    logic                 ack_q;
    npc_sel_e             npc_sel;
    logic [PC_W-1:0]      next_pc;

    // Halt outranks branch, so only a non-halting consume may redirect.
    assign npc_sel = (valid_q && BranchTaken && !HaltReq)
                   ? (BranchRel ? NPC_REL : NPC_ABS) : NPC_SEQ;

    fetch_next_pc #(
        .PC_W  (PC_W),
        .OFS_W (OFS_W)
    ) u_next_pc (
        .sel_i      (npc_sel),
        .fetch_pc_i (fetch_pc_q),
        .instr_pc_i (instr_pc_q),
        .offset_i   (Offset),
        .target_i   (Target),
        .next_pc_o  (next_pc)
    );

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        ir_d       = ir_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
        count_d    = count_q;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (Start) begin
                    state_d    = ST_RUN;
                    fetch_pc_d = StartAddr;
                    count_d    = '0;
                    valid_d    = 1'b0;
                end
            end
            ST_RUN: begin
                if (!Stall) begin
                    if (valid_q && count_q != 16'hFFFF) begin
                        count_d = count_q + 16'd1;
                    end
                    if (valid_q && HaltReq) begin
                        state_d = ST_HALT;
                        valid_d = 1'b0;
                    end else if (valid_q && BranchTaken) begin
                        fetch_pc_d = next_pc;
                        valid_d    = 1'b0;
                    end else begin
                        ir_d       = ImemData;
                        instr_pc_d = fetch_pc_q;
                        fetch_pc_d = next_pc;
                        valid_d    = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= '0;
            ir_q       <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
            count_q    <= '0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            ir_q       <= ir_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
            count_q    <= count_d;
            ack_q      <= (state_d == ST_HALT);
        end
    end

    assign ImemAddr   = fetch_pc_q;
    assign Instr      = ir_q;
    assign Opcode     = ir_q[INSTR_W-1 -: OPC_W];
    assign InstrValid = valid_q;
    assign InstrPC    = instr_pc_q;
    assign InstrCount = count_q;
    assign Ack        = ack_q;

endmodule
